mem_stage: RTL

Dcache→mem pipeline register and load-result formatter for the MIPS core. Each cycle it captures the dcache-stage write-back bundle and the synchronous `data_sram_rdata` return. It holds the raw read word across stalls so the data is not lost when the SRAM output changes. It aligns, sign-extends or merges loads (lb/lbu/lh/lhu/lw/lwl/lwr) and presents the registered `mem_we/mem_waddr/mem_wdata` bundle to the register file and the forwarding unit.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_if.sv | 34 +++
 rtl/mem_stage_load_align.sv | 64 ++++++
 rtl/mem_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the dcache->mem pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_stage_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int STALL_BUS    = 8;
    localparam int MEM_OP_BUS   = 7;

    // Stall-bus bit indices and their polarity.
    localparam int   STALL_DC  = 6;
    localparam int   STALL_MEM = 7;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    typedef logic [REG_BUS-1:0]      reg_t;
    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
    typedef logic [STALL_BUS-1:0]    stall_t;
    typedef logic [MEM_OP_BUS-1:0]   mem_op_t;

    // One-hot load opcodes, bit order {lwl, lwr, lb, lbu, lh, lhu, lw}.
    localparam mem_op_t OP_LW  = 7'b000_0001;
    localparam mem_op_t OP_LHU = 7'b000_0010;
    localparam mem_op_t OP_LH  = 7'b000_0100;
    localparam mem_op_t OP_LBU = 7'b000_1000;
    localparam mem_op_t OP_LB  = 7'b001_0000;
    localparam mem_op_t OP_LWR = 7'b010_0000;
    localparam mem_op_t OP_LWL = 7'b100_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

    // Register-file write-back bundle.
    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        reg_t      wdata;
    } wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle between the dcache stage / data SRAM and the mem stage write-back.
// Latency: n/a (wiring only).
// Backpressure: stall bits travel with the bundle; no valid/ready here.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic      flush;
    stall_t    stall;
    logic      dc_we;
    reg_addr_t dc_waddr;
    reg_t      dc_wdata;
    mem_op_t   dc_mem_op;
    reg_addr_t dc_rt_rf_raddr;
    reg_t      dc_rt_rf_rdata;
    reg_t      data_sram_rdata;
    logic      mem_we;
    reg_addr_t mem_waddr;
    reg_t      mem_wdata;

    // Upstream side: drives the dcache bundle, observes write-back.
    modport master (
        output flush, stall, dc_we, dc_waddr, dc_wdata, dc_mem_op,
               dc_rt_rf_raddr, dc_rt_rf_rdata, data_sram_rdata,
        input  mem_we, mem_waddr, mem_wdata
    );

    // The mem stage itself.
    modport slave (
        input  flush, stall, dc_we, dc_waddr, dc_wdata, dc_mem_op,
               dc_rt_rf_raddr, dc_rt_rf_rdata, data_sram_rdata,
        output mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load result formatter: lane select, sign/zero extend, lwl/lwr merge.
// Latency: purely combinational.
// Backpressure: none; also reused by the forwarding path.
module load_align
    import mem_stage_pkg::*;
(
    input  mem_op_t    mem_op,
    input  logic [1:0] off,
    input  reg_t       rdata_eff,
    input  reg_t       reg2,
    input  reg_t       alu_result,
    output reg_t       result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes of the read word.
    always_comb begin
        byte_sel = rdata_eff[7:0];
        half_sel = rdata_eff[15:0];
        case (off)
            2'd0: byte_sel = rdata_eff[7:0];
            2'd1: byte_sel = rdata_eff[15:8];
            2'd2: byte_sel = rdata_eff[23:16];
            2'd3: byte_sel = rdata_eff[31:24];
            default: byte_sel = rdata_eff[7:0];
        endcase
        if (off[1]) begin
            half_sel = rdata_eff[31:16];
        end
    end

    // Format by opcode; anything that is not a recognised load passes the ALU result.
    always_comb begin
        result = alu_result;
        case (mem_op)
            OP_LW:  result = rdata_eff;
            OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: result = {24'h0, byte_sel};
            // Odd halfword offsets are misaligned; the exception is raised elsewhere.
            OP_LH:  result = off[0] ? '0 : {{16{half_sel[15]}}, half_sel};
            OP_LHU: result = off[0] ? '0 : {16'h0, half_sel};
            OP_LWL: begin
                case (off)
                    2'd0: result = {rdata_eff[7:0],  reg2[23:0]};
                    2'd1: result = {rdata_eff[15:0], reg2[15:0]};
                    2'd2: result = {rdata_eff[23:0], reg2[7:0]};
                    default: result = rdata_eff;
                endcase
            end
            OP_LWR: begin
                case (off)
                    2'd0: result = rdata_eff;
                    2'd1: result = {reg2[31:24], rdata_eff[31:8]};
                    2'd2: result = {reg2[31:16], rdata_eff[31:16]};
                    default: result = {reg2[31:8], rdata_eff[31:24]};
                endcase
            end
            default: result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Dcache->mem pipeline register with SRAM read-word hold and load formatting.
// Latency: one edge from an advancing dcache-stage cycle to mem_* outputs.
// Backpressure: stall[6]/stall[7] freeze, bubble or advance; flush clears.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);

    hold_state_t hold_state;
    hold_state_t hold_state_nxt;
    reg_t        rdata_hold;
    reg_t        rdata_hold_nxt;
    logic        hold_valid;

    wb_t         wb_q;
    wb_t         wb_adv;
    reg_t        rdata_eff;
    reg_t        reg2;
    reg_t        fmt_result;

    logic        dc_stop;
    logic        mem_stop;

    // Stall bits outside the dcache/mem pair belong to other stages.
    logic        unused_stall;
    assign unused_stall = ^bus.stall[5:0];

    assign dc_stop    = (bus.stall[STALL_DC]  == STOP);
    assign mem_stop   = (bus.stall[STALL_MEM] == STOP);
    assign hold_valid = (hold_state == HELD);

    // The SRAM word is only valid in the dcache cycle, so a held copy takes over during stalls.
    assign rdata_eff = hold_valid ? rdata_hold : bus.data_sram_rdata;

    // Back-to-back lwl/lwr to the same rt must merge into the value still in this stage.
    assign reg2 = (wb_q.we && (wb_q.waddr == bus.dc_rt_rf_raddr)) ? wb_q.wdata
                                                                   : bus.dc_rt_rf_rdata;

    load_align u_load_align (
        .mem_op     (bus.dc_mem_op),
        .off        (bus.dc_wdata[1:0]),
        .rdata_eff  (rdata_eff),
        .reg2       (reg2),
        .alu_result (bus.dc_wdata),
        .result     (fmt_result)
    );

    assign wb_adv = '{we: bus.dc_we, waddr: bus.dc_waddr, wdata: fmt_result};

    // Hold FSM state and captured read word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_state <= EMPTY;
            rdata_hold <= '0;
        end else begin
            hold_state <= hold_state_nxt;
            rdata_hold <= rdata_hold_nxt;
        end
    end

    // Capture once when both stages stop; release on flush or when dcache advances.
    always_comb begin
        hold_state_nxt = hold_state;
        rdata_hold_nxt = rdata_hold;
        case (hold_state)
            EMPTY: begin
                if (!bus.flush && dc_stop && mem_stop) begin
                    hold_state_nxt = HELD;
                    rdata_hold_nxt = bus.data_sram_rdata;
                end
            end
            HELD: begin
                if (bus.flush || !dc_stop) begin
                    hold_state_nxt = EMPTY;
                    rdata_hold_nxt = '0;
                end
            end
            default: begin
                hold_state_nxt = EMPTY;
                rdata_hold_nxt = '0;
            end
        endcase
    end

    // Output register: flush, then bubble, then advance, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= '0;
        end else if (bus.flush) begin
            wb_q <= '0;
        end else if (dc_stop && !mem_stop) begin
            wb_q <= '0;
        end else if (!dc_stop) begin
            wb_q <= wb_adv;
        end
    end

    assign bus.mem_we    = wb_q.we;
    assign bus.mem_waddr = wb_q.waddr;
    assign bus.mem_wdata = wb_q.wdata;

endmodule
